// File: rtl/pixel_timing_ctrl.sv
// Stream-timing controller: tracks raster position from de/hsync/vsync, flags
// KSIZE x KSIZE window validity, and delays the controls to match the datapath.
//
// state   | meaning
// WAIT_VS | idle or recovering from a framing error; de ignored until vsync rises
// ACTIVE  | inside a frame; counting pixels and lines

module pixel_timing_ctrl #(
  parameter int H_ACT = 64,
  parameter int V_ACT = 64,
  parameter int KSIZE = 3,
  parameter int LAT   = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_de,
  input  logic        in_hsync,
  input  logic        in_vsync,
  output logic        pix_valid,
  output logic [11:0] x,
  output logic [11:0] y,
  output logic        win_valid,
  output logic        frame_start,
  output logic        frame_done,
  output logic        err,
  output logic        al_de,
  output logic        al_hsync,
  output logic        al_vsync,
  output logic        al_win
);

  localparam logic [11:0] H_END = 12'(H_ACT);
  localparam logic [11:0] V_END = 12'(V_ACT);
  localparam logic [11:0] K_MIN = 12'(KSIZE - 1);

  typedef enum logic {
    WAIT_VS = 1'b0,
    ACTIVE  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [11:0] xcnt_q, xcnt_d;
  logic [11:0] ycnt_q, ycnt_d;
  logic        vs_q, de_q;
  logic        vs_rise, de_fall;

  logic        accept;
  logic [11:0] acc_x, acc_y;
  logic        err_d, done_d;

  assign vs_rise = in_vsync & ~vs_q;
  assign de_fall = de_q & ~in_de;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= WAIT_VS;
      xcnt_q  <= '0;
      ycnt_q  <= '0;
      vs_q    <= 1'b1;  // a vsync already high at reset release is not a frame start
      de_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      xcnt_q  <= xcnt_d;
      ycnt_q  <= ycnt_d;
      vs_q    <= in_vsync;
      de_q    <= in_de;
    end
  end

  always_comb begin
    state_d = state_q;
    xcnt_d  = xcnt_q;
    ycnt_d  = ycnt_q;
    accept  = 1'b0;
    acc_x   = xcnt_q;
    acc_y   = ycnt_q;
    err_d   = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      WAIT_VS: begin
        if (vs_rise) begin
          state_d = ACTIVE;
          xcnt_d  = '0;
          ycnt_d  = '0;
        end
      end
      ACTIVE: begin
        if (vs_rise) begin
          // restart wins over everything; an unfinished previous frame is flagged
          xcnt_d = '0;
          ycnt_d = '0;
          err_d  = (ycnt_q != V_END);
          if (in_de) begin
            accept = 1'b1;
            acc_x  = '0;
            acc_y  = '0;
            xcnt_d = 12'd1;
          end
        end else if (in_de && ((xcnt_q == H_END) || (ycnt_q == V_END))) begin
          err_d   = 1'b1;
          state_d = WAIT_VS;
        end else if (in_de) begin
          accept = 1'b1;
          xcnt_d = xcnt_q + 12'd1;
        end else if (de_fall) begin
          if (xcnt_q != H_END) begin
            err_d   = 1'b1;
            state_d = WAIT_VS;
          end else begin
            xcnt_d = '0;
            ycnt_d = ycnt_q + 12'd1;
            done_d = ((ycnt_q + 12'd1) == V_END);
          end
        end
      end
      default: state_d = WAIT_VS;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pix_valid   <= 1'b0;
      x           <= '0;
      y           <= '0;
      win_valid   <= 1'b0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      err         <= 1'b0;
    end else begin
      pix_valid   <= accept;
      if (accept) begin
        x <= acc_x;
        y <= acc_y;
      end
      win_valid   <= accept && (acc_x >= K_MIN) && (acc_y >= K_MIN);
      frame_start <= accept && (acc_x == 12'd0) && (acc_y == 12'd0);
      frame_done  <= done_d;
      err         <= err_d;
    end
  end

  logic [LAT-1:0] de_sr, hs_sr, vs_sr;

  always_ff @(posedge clk) begin
    if (rst) begin
      de_sr <= '0;
      hs_sr <= '0;
      vs_sr <= '0;
    end else begin
      de_sr[0] <= in_de;
      hs_sr[0] <= in_hsync;
      vs_sr[0] <= in_vsync;
      for (int k = 1; k < LAT; k++) begin
        de_sr[k] <= de_sr[k-1];
        hs_sr[k] <= hs_sr[k-1];
        vs_sr[k] <= vs_sr[k-1];
      end
    end
  end

  assign al_de    = de_sr[LAT-1];
  assign al_hsync = hs_sr[LAT-1];
  assign al_vsync = vs_sr[LAT-1];

  // win_valid is already one register past the input, so its path is one stage shorter
  generate
    if (LAT > 1) begin : g_win_dly
      logic [LAT-2:0] win_sr;
      always_ff @(posedge clk) begin
        if (rst) begin
          win_sr <= '0;
        end else begin
          win_sr[0] <= win_valid;
          for (int k = 1; k < LAT - 1; k++) begin
            win_sr[k] <= win_sr[k-1];
          end
        end
      end
      assign al_win = win_sr[LAT-2];
    end else begin : g_win_pass
      assign al_win = win_valid;
    end
  endgenerate

endmodule

// File: tb/tb_pixel_timing_ctrl.sv
// Directed bench for pixel_timing_ctrl at H_ACT=V_ACT=4, KSIZE=3, LAT=5.
// Inputs change 1ns after a rising edge; outputs are sampled at the same point.

module tb_pixel_timing_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_de, in_hsync, in_vsync;
  logic        pix_valid;
  logic [11:0] x, y;
  logic        win_valid, frame_start, frame_done, err;
  logic        al_de, al_hsync, al_vsync, al_win;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pixel_timing_ctrl #(
    .H_ACT(4),
    .V_ACT(4),
    .KSIZE(3),
    .LAT  (5)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_de      (in_de),
    .in_hsync   (in_hsync),
    .in_vsync   (in_vsync),
    .pix_valid  (pix_valid),
    .x          (x),
    .y          (y),
    .win_valid  (win_valid),
    .frame_start(frame_start),
    .frame_done (frame_done),
    .err        (err),
    .al_de      (al_de),
    .al_hsync   (al_hsync),
    .al_vsync   (al_vsync),
    .al_win     (al_win)
  );

  // {pix_valid, x, y, win_valid, frame_start, frame_done, err}
  function automatic logic [28:0] core_obs();
    return {pix_valid, x, y, win_valid, frame_start, frame_done, err};
  endfunction

  function automatic logic [3:0] al_obs();
    return {al_de, al_hsync, al_vsync, al_win};
  endfunction

  function automatic logic [28:0] mk(input bit pv, input int ex, input int ey,
                                     input bit w, input bit fs, input bit fd, input bit er);
    return {pv, 12'(ex), 12'(ey), w, fs, fd, er};
  endfunction

  task automatic cyc(input logic de, input logic hs, input logic vs);
    in_de    = de;
    in_hsync = hs;
    in_vsync = vs;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    n_vec++;
    if ({core_obs(), al_obs()} !== 33'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h want 0", {core_obs(), al_obs()});
    end
    rst = 1'b0;
  endtask

  task automatic test_nominal();
    logic de_v[34], hs_v[34], vs_v[34], w_v[34];
    logic [28:0] e_core;
    logic [3:0]  e_al;
    int ex, ey, wins;
    for (int i = 0; i < 34; i++) begin
      de_v[i] = 0; hs_v[i] = 0; vs_v[i] = 0; w_v[i] = 0;
    end
    vs_v[1] = 1;
    hs_v[2] = 1;
    for (int l = 0; l < 4; l++) begin
      for (int p = 0; p < 4; p++) begin
        de_v[4 + 6*l + p] = 1;
        w_v[4 + 6*l + p]  = (p >= 2) && (l >= 2);
      end
      hs_v[4 + 6*l + 4] = 1;
    end
    ex = 0; ey = 0; wins = 0;
    for (int i = 0; i < 34; i++) begin
      cyc(de_v[i], hs_v[i], vs_v[i]);
      if (de_v[i]) begin
        ex = (i - 4) % 6;
        ey = (i - 4) / 6;
      end
      e_core = mk(de_v[i], ex, ey, w_v[i], de_v[i] && ex == 0 && ey == 0, i == 26, 1'b0);
      n_vec++;
      if (core_obs() !== e_core) begin
        n_err++;
        $display("FAIL nominal_core[%0d]: got %h want %h", i, core_obs(), e_core);
      end
      e_al = 4'b0;
      if (i >= 4) e_al = {de_v[i-4], hs_v[i-4], vs_v[i-4], w_v[i-4]};
      n_vec++;
      if (al_obs() !== e_al) begin
        n_err++;
        $display("FAIL nominal_aligned[%0d]: got %b want %b", i, al_obs(), e_al);
      end
      if (win_valid === 1'b1) wins++;
    end
    n_vec++;
    if (wins != 4) begin
      n_err++;
      $display("FAIL nominal_win_count: got %0d want 4", wins);
    end
  endtask

  task automatic test_alignment();
    logic [28:0] e_core;
    logic [3:0]  e_al;
    cyc(0, 0, 1);
    n_vec++;
    if (core_obs() !== mk(0, 3, 3, 0, 0, 0, 0)) begin
      n_err++;
      $display("FAIL align_new_frame: got %h want %h", core_obs(), mk(0, 3, 3, 0, 0, 0, 0));
    end
    cyc(0, 0, 0);
    cyc(1, 0, 0);
    n_vec++;
    if ({core_obs(), al_de} !== {mk(1, 0, 0, 0, 1, 0, 0), 1'b0}) begin
      n_err++;
      $display("FAIL align_pix: got %h want %h", {core_obs(), al_de}, {mk(1, 0, 0, 0, 1, 0, 0), 1'b0});
    end
    for (int k = 1; k <= 5; k++) begin
      cyc(0, 0, 0);
      e_core = mk(0, 0, 0, 0, 0, 0, k == 1);
      e_al   = {k == 4, 1'b0, k == 2, 1'b0};
      n_vec++;
      if (core_obs() !== e_core) begin
        n_err++;
        $display("FAIL align_core[%0d]: got %h want %h", k, core_obs(), e_core);
      end
      n_vec++;
      if (al_obs() !== e_al) begin
        n_err++;
        $display("FAIL align_al[%0d]: got %b want %b", k, al_obs(), e_al);
      end
    end
  endtask

  task automatic test_short_line();
    cyc(0, 0, 1);
    cyc(0, 0, 0);
    for (int p = 0; p < 4; p++) begin
      cyc(1, 0, 0);
      n_vec++;
      if (core_obs() !== mk(1, p, 0, 0, p == 0, 0, 0)) begin
        n_err++;
        $display("FAIL short_line0[%0d]: got %h want %h", p, core_obs(), mk(1, p, 0, 0, p == 0, 0, 0));
      end
    end
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    for (int p = 0; p < 3; p++) begin
      cyc(1, 0, 0);
      n_vec++;
      if (core_obs() !== mk(1, p, 1, 0, 0, 0, 0)) begin
        n_err++;
        $display("FAIL short_line1[%0d]: got %h want %h", p, core_obs(), mk(1, p, 1, 0, 0, 0, 0));
      end
    end
    cyc(0, 0, 0);
    n_vec++;
    if (core_obs() !== mk(0, 2, 1, 0, 0, 0, 1)) begin
      n_err++;
      $display("FAIL short_err: got %h want %h", core_obs(), mk(0, 2, 1, 0, 0, 0, 1));
    end
    cyc(0, 0, 0);
    for (int p = 0; p < 5; p++) begin
      cyc(p < 4, 0, 0);
      n_vec++;
      if (core_obs() !== mk(0, 2, 1, 0, 0, 0, 0)) begin
        n_err++;
        $display("FAIL short_ignored[%0d]: got %h want %h", p, core_obs(), mk(0, 2, 1, 0, 0, 0, 0));
      end
    end
    cyc(0, 0, 1);
    cyc(0, 0, 0);
    for (int p = 0; p < 4; p++) begin
      cyc(1, 0, 0);
      n_vec++;
      if (core_obs() !== mk(1, p, 0, 0, p == 0, 0, 0)) begin
        n_err++;
        $display("FAIL short_recover[%0d]: got %h want %h", p, core_obs(), mk(1, p, 0, 0, p == 0, 0, 0));
      end
    end
    cyc(0, 0, 0);
    n_vec++;
    if (core_obs() !== mk(0, 3, 0, 0, 0, 0, 0)) begin
      n_err++;
      $display("FAIL short_recover_eol: got %h want %h", core_obs(), mk(0, 3, 0, 0, 0, 0, 0));
    end
  endtask

  task automatic test_overrun();
    for (int p = 0; p < 5; p++) begin
      cyc(1, 0, 0);
      n_vec++;
      if (core_obs() !== mk(p < 4, p < 4 ? p : 3, 1, 0, 0, 0, p == 4)) begin
        n_err++;
        $display("FAIL overrun[%0d]: got %h want %h", p, core_obs(), mk(p < 4, p < 4 ? p : 3, 1, 0, 0, 0, p == 4));
      end
    end
    cyc(0, 0, 0);
    n_vec++;
    if (core_obs() !== mk(0, 3, 1, 0, 0, 0, 0)) begin
      n_err++;
      $display("FAIL overrun_fall: got %h want %h", core_obs(), mk(0, 3, 1, 0, 0, 0, 0));
    end
    cyc(0, 0, 1);
    cyc(0, 0, 0);
    for (int l = 0; l < 4; l++) begin
      for (int p = 0; p < 4; p++) begin
        cyc(1, 0, 0);
        n_vec++;
        if (core_obs() !== mk(1, p, l, p >= 2 && l >= 2, p == 0 && l == 0, 0, 0)) begin
          n_err++;
          $display("FAIL extra_frame[%0d,%0d]: got %h want %h", p, l, core_obs(),
                   mk(1, p, l, p >= 2 && l >= 2, p == 0 && l == 0, 0, 0));
        end
      end
      cyc(0, 0, 0);
      n_vec++;
      if (core_obs() !== mk(0, 3, l, 0, 0, l == 3, 0)) begin
        n_err++;
        $display("FAIL extra_eol[%0d]: got %h want %h", l, core_obs(), mk(0, 3, l, 0, 0, l == 3, 0));
      end
    end
    for (int p = 0; p < 5; p++) begin
      cyc(p < 4, 0, 0);
      n_vec++;
      if (core_obs() !== mk(0, 3, 3, 0, 0, 0, p == 0)) begin
        n_err++;
        $display("FAIL extra_line[%0d]: got %h want %h", p, core_obs(), mk(0, 3, 3, 0, 0, 0, p == 0));
      end
    end
  endtask

  task automatic test_vs_mid_frame();
    cyc(0, 0, 1);
    cyc(0, 0, 0);
    for (int l = 0; l < 2; l++) begin
      for (int p = 0; p < 4; p++) cyc(1, 0, 0);
      cyc(0, 0, 0);
    end
    for (int p = 0; p < 2; p++) begin
      cyc(1, 0, 0);
      n_vec++;
      if (core_obs() !== mk(1, p, 2, 0, 0, 0, 0)) begin
        n_err++;
        $display("FAIL vsmid_pre[%0d]: got %h want %h", p, core_obs(), mk(1, p, 2, 0, 0, 0, 0));
      end
    end
    cyc(1, 0, 1);
    n_vec++;
    if (core_obs() !== mk(1, 0, 0, 0, 1, 0, 1)) begin
      n_err++;
      $display("FAIL vsmid_restart: got %h want %h", core_obs(), mk(1, 0, 0, 0, 1, 0, 1));
    end
    for (int p = 1; p < 4; p++) begin
      cyc(1, 0, 0);
      n_vec++;
      if (core_obs() !== mk(1, p, 0, 0, 0, 0, 0)) begin
        n_err++;
        $display("FAIL vsmid_post[%0d]: got %h want %h", p, core_obs(), mk(1, p, 0, 0, 0, 0, 0));
      end
    end
    cyc(0, 0, 0);
    n_vec++;
    if (core_obs() !== mk(0, 3, 0, 0, 0, 0, 0)) begin
      n_err++;
      $display("FAIL vsmid_eol: got %h want %h", core_obs(), mk(0, 3, 0, 0, 0, 0, 0));
    end
  endtask

  task automatic test_reset_mid();
    for (int p = 0; p < 3; p++) cyc(1, 0, 0);
    n_vec++;
    if (core_obs() !== mk(1, 2, 1, 0, 0, 0, 0)) begin
      n_err++;
      $display("FAIL rstmid_pos: got %h want %h", core_obs(), mk(1, 2, 1, 0, 0, 0, 0));
    end
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      cyc(1, 0, 1);
      n_vec++;
      if ({core_obs(), al_obs()} !== 33'd0) begin
        n_err++;
        $display("FAIL rstmid_zero[%0d]: got %h want 0", k, {core_obs(), al_obs()});
      end
    end
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cyc((k % 5) != 4, 0, 1);
      n_vec++;
      if (core_obs() !== 29'd0) begin
        n_err++;
        $display("FAIL rstmid_vs_held[%0d]: got %h want 0", k, core_obs());
      end
    end
    cyc(0, 0, 0);
    cyc(0, 0, 1);
    cyc(0, 0, 0);
    for (int p = 0; p < 4; p++) begin
      cyc(1, 0, 0);
      n_vec++;
      if (core_obs() !== mk(1, p, 0, 0, p == 0, 0, 0)) begin
        n_err++;
        $display("FAIL rstmid_restart[%0d]: got %h want %h", p, core_obs(), mk(1, p, 0, 0, p == 0, 0, 0));
      end
    end
    cyc(0, 0, 0);
  endtask

  initial begin
    rst      = 1'b1;
    in_de    = 1'b0;
    in_hsync = 1'b0;
    in_vsync = 1'b0;
    test_reset();
    test_nominal();
    test_alignment();
    test_short_line();
    test_overrun();
    test_vs_mid_frame();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule

// File: doc/pixel_timing_ctrl.md
# pixel_timing_ctrl

Stream-timing controller placed at the input of the image-processing pipeline. It tracks frame position from the raw de/hsync/vsync stream and produces registered pixel coordinates and KSIZE×KSIZE window-validity flags. It also outputs a copy of the sync/valid controls delayed by the datapath latency LAT, so the fixed-latency pixel datapath and its control stay aligned. It detects malformed frames and resynchronises on the next vsync.

## Interface
- H_ACT, 64, active pixels per line (1..4095)
- V_ACT, 64, active lines per frame (1..4095)
- KSIZE, 3, window size; window valid when x ≥ KSIZE-1 and y ≥ KSIZE-1 (1..min(H_ACT,V_ACT))
- LAT, 5, datapath latency in clk cycles for aligned outputs (≥1)

Ports:
- clk  in  1  sole clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_de  in  1  active-pixel strobe
- in_hsync  in  1  line sync (passed through only)
- in_vsync  in  1  frame sync; rising edge starts a frame
- pix_valid  out  1  registered copy of accepted in_de
- x  out  12  column of current pixel
- y  out  12  row of current pixel
- win_valid  out  1  pix_valid and x ≥ KSIZE-1 and y ≥ KSIZE-1
- frame_start  out  1  one-cycle pulse with pixel (0,0)
- frame_done  out  1  one-cycle pulse when line V_ACT-1 completes correctly
- err  out  1  one-cycle pulse on any framing violation
- al_de, al_hsync, al_vsync, al_win  out  1 each  in_de, in_hsync, in_vsync, win_valid delayed to LAT cycles after input sample

## Operation
- Edge detect: vs_q, de_q registered. vs_rise = in_vsync & ~vs_q. de_fall = de_q & ~in_de. vs_q resets to 1, so a vsync already high at reset release is not an edge. de_q resets to 0.
- Internal counters xcnt, ycnt are 12 bits. FSM has two states, WAIT_VS and ACTIVE.
- WAIT_VS (reset state): in_de ignored; pix_valid=0. vs_rise → ACTIVE, with xcnt=ycnt=0.
- ACTIVE, priority order per cycle:
  1. vs_rise: xcnt=ycnt=0, stay ACTIVE. If ycnt ≠ V_ACT (previous frame incomplete), pulse err. If in_de is high the same cycle, that pixel is accepted as (0,0).
  2. in_de with xcnt == H_ACT (line overrun), or in_de with ycnt == V_ACT (extra line): pulse err → WAIT_VS; pixel not accepted.
  3. in_de otherwise: accept pixel; x←xcnt, y←ycnt, xcnt+1.
  4. de_fall: if xcnt ≠ H_ACT → err, WAIT_VS. Else xcnt=0, ycnt+1. If ycnt+1 == V_ACT, pulse frame_done.
- frame_start is asserted when accepted pixel has xcnt=0, ycnt=0.
- x, y hold last accepted value when pix_valid=0. x, y reset to 0.
- Aligned outputs use a LAT-stage shift register of {de,hsync,vsync,win}. win enters at stage 1 from the registered win_valid, so its shift path is LAT-1 deep. All four therefore emerge LAT cycles after the input sample. All stages clear on rst.
- No back-pressure; one pixel per cycle maximum; in_hsync is not checked.

## Timing
- Reset: the cycle after rst is sampled high, every output is 0, FSM is WAIT_VS, and all delay stages are 0. This holds mid-frame too; the next frame requires a fresh vsync rising edge.
- Latency: pix_valid, x, y, win_valid, frame_start, frame_done, and err update one cycle after the causing input sample. al_* outputs update LAT cycles after it.
- All pulse outputs are exactly one cycle wide.
- Back-to-back frames: a vsync rise may coincide with the first de of the next frame. Gaps between lines and frames may be any length, including 0 blanking cycles between de_fall and the next de.
- err never blocks: after err the block is in WAIT_VS or restarted ACTIVE as listed above. Only the first violation per cycle is signalled (single pulse).

## Test plan
- Nominal: H_ACT=V_ACT=4, KSIZE=3. Drive vsync pulse, then 4 lines of 4 de cycles with 2-cycle gaps. Required: x,y sweep 0..3 in raster order; frame_start with (0,0); win_valid exactly for x,y ∈ {2,3} (4 pixels); frame_done one cycle after last de_fall; err never.
- Alignment: LAT=5, single de pulse at cycle t. Required: pix_valid at t+1, al_de at t+5, al_win equal to win_valid delayed 4 cycles.
- Short line: 3 de cycles on line 1 (H_ACT=4). Required: err pulse one cycle after de_fall; pix_valid stays 0 until next vsync rise; next frame counts from (0,0) correctly.
- Overrun/extra line: 5th de in a line → err, pixel rejected. Separately, a 5th line after frame_done → err, WAIT_VS.
- Simultaneous vsync rise and de mid-frame (ycnt=2): required err pulse, frame_start, x=0, y=0 same cycle.
- Reset mid-frame at (2,1): all outputs 0 next cycle. Hold vsync high through reset release → no frame starts until vsync falls and rises again.
